morse_symbol_detector: RTL and testbench
========================================

MORSE_SYMBOL_DETECTOR -- requirements
Module: morse_symbol_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the press and gap counters.
REQ-002 SHALL have parameter DEB, default 4, debounce stability length in clk cycles.
REQ-003 SHALL have parameter DOT_MAX, default 10, longest press in cycles classed as a dot.
REQ-004 SHALL have parameter DASH_MAX, default 40, longest press in cycles classed as a dash.
REQ-005 SHALL have parameter LETTER_GAP, default 30, low-time in cycles that ends a letter.
REQ-006 SHALL have parameter WORD_GAP, default 70, low-time in cycles that ends a word.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port key_in, input, 1, raw asynchronous Morse key, 1 = pressed.
REQ-010 SHALL have port symbol_valid, output, 1, one-cycle pulse, symbol_dot valid.
REQ-011 SHALL have port symbol_dot, output, 1, 1 = dot, 0 = dash; the decoder's input polarity.
REQ-012 SHALL have port letter_end, output, 1, one-cycle pulse, current letter complete.
REQ-013 SHALL have port word_end, output, 1, one-cycle pulse, current word complete.
REQ-014 SHALL have port err, output, 1, one-cycle pulse, malformed input detected.
REQ-015 SHALL have port busy, output, 1, level, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL synchronise key_in through two flops to key_s; key_s SHALL be the only use of key_in.
REQ-017 SHALL drive key_db to the value of key_s after key_s has differed from key_db for DEB consecutive cycles.
REQ-018 SHALL implement FSM states IDLE, PRESS, GAP and DISCARD.
REQ-019 SHALL move IDLE->PRESS on key_db=1; IDLE SHALL NOT count gaps or emit letter_end or word_end.
REQ-020 SHALL count key_db=1 cycles as press_len in PRESS, saturating at DASH_MAX+1.
REQ-021 SHALL, on the first key_db=0 cycle in PRESS with press_len<=DOT_MAX, pulse symbol_valid with symbol_dot=1 on the next cycle and enter GAP.
REQ-022 SHALL, on that release with DOT_MAX<press_len<=DASH_MAX, pulse symbol_valid with symbol_dot=0 and enter GAP.
REQ-023 SHALL, when press_len reaches DASH_MAX+1 while key_db is still 1, pulse err once, emit no symbol and enter DISCARD.
REQ-024 SHALL track symbols per letter in sym_cnt (0..4); a release that would be a 5th symbol SHALL pulse err instead of symbol_valid and enter DISCARD.
REQ-025 SHALL count consecutive key_db=0 cycles as gap_len in GAP, cleared on entry.
REQ-026 SHALL, in GAP, pulse letter_end when gap_len reaches LETTER_GAP and clear sym_cnt.
REQ-027 SHALL, in GAP, pulse word_end when gap_len reaches WORD_GAP and return to IDLE.
REQ-028 SHALL, on key_db=1 in GAP, go to PRESS with sym_cnt kept before LETTER_GAP, or with sym_cnt=0 after it.
REQ-029 SHALL, in DISCARD, wait for LETTER_GAP consecutive key_db=0 cycles, any key_db=1 restarting the count, then pulse letter_end, clear sym_cnt and go to IDLE; no word_end.
REQ-030 SHALL register all outputs, never assert two of symbol_valid, letter_end and word_end in one cycle, and hold symbol_dot between pulses.
REQ-031 SHALL require DOT_MAX<DASH_MAX<2^CNT_W-1 and LETTER_GAP<WORD_GAP<2^CNT_W-1.

Reset
REQ-032 SHALL, on reset, clear the synchroniser, key_db, counters, sym_cnt and all outputs to 0 and put the FSM in IDLE.
REQ-033 SHALL abort any in-progress press, gap or discard on mid-operation reset, with no pulse in or after the reset cycle.
REQ-034 SHALL treat a key held through reset as a new press once debounced, counted from the key_db rise.

Verification
REQ-035 SHALL pass: press 6, low 80 -> symbol_valid, symbol_dot=1; letter_end at gap 30, word_end at gap 70, busy=0 after.
REQ-036 SHALL pass: press 20, low 10, press 5, low 80 -> dash, then dot, then one letter_end and one word_end.
REQ-037 SHALL pass: press 50 -> err at press cycle 41, no symbol; low 30 -> letter_end, IDLE, no word_end.
REQ-038 SHALL pass: five dots of 5 high / 10 low each -> four symbol_valid, err at fifth release, letter_end 30 cycles later.
REQ-039 SHALL pass: 2-cycle glitches on key_in, with DEB=4 -> no symbol_valid, busy=0.
REQ-040 SHALL pass: reset at press cycle 8 -> all outputs 0, no symbol after reset deasserts with key low.

Source files
------------

// File: rtl/morse_symbol_detector.sv
// -----------------------------------------------------------------------------
// morse_symbol_detector
//
// Turns a raw, bouncy Morse key into a stream of classified symbols (dot/dash)
// with letter and word boundary markers for a downstream decoder.
//
// The key is synchronised through two flops and debounced. A four-state FSM
// then measures press lengths and gap lengths:
//   IDLE    - waiting for the first press. Gaps are not timed here.
//   PRESS   - counting a press. A press that runs past DASH_MAX is an error.
//   GAP     - counting low time. Reaching LETTER_GAP ends the letter.
//             Reaching WORD_GAP ends the word and returns to IDLE.
//   DISCARD - recovery after an error. The FSM waits for a clean LETTER_GAP
//             of low time, then closes the letter.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   key_in       in   raw asynchronous key, 1 = pressed
//   symbol_valid out  one-cycle pulse, symbol_dot is valid
//   symbol_dot   out  1 = dot, 0 = dash; held between pulses
//   letter_end   out  one-cycle pulse, current letter complete
//   word_end     out  one-cycle pulse, current word complete
//   err          out  one-cycle pulse, malformed input (long press / 5th symbol)
//   busy         out  level, FSM is not in IDLE
//
// Parameter constraints: DOT_MAX < DASH_MAX < 2^CNT_W-1 and
// LETTER_GAP < WORD_GAP < 2^CNT_W-1.
// -----------------------------------------------------------------------------
module morse_symbol_detector #(
  parameter int CNT_W      = 8,
  parameter int DEB        = 4,
  parameter int DOT_MAX    = 10,
  parameter int DASH_MAX   = 40,
  parameter int LETTER_GAP = 30,
  parameter int WORD_GAP   = 70
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic symbol_valid,
  output logic symbol_dot,
  output logic letter_end,
  output logic word_end,
  output logic err,
  output logic busy
);

  // The debounce counter only has to reach DEB-1.
  localparam int DB_W = (DEB < 2) ? 1 : $clog2(DEB);

  localparam logic [CNT_W-1:0] PRESS_SAT = CNT_W'(DASH_MAX + 1);
  localparam logic [CNT_W-1:0] DOT_LIM   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LGAP      = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WGAP      = CNT_W'(WORD_GAP);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    DISCARD
  } state_e;

  // Synchroniser and debouncer
  logic            key_meta_q;
  logic            key_s_q;
  logic            key_db_q;
  logic [DB_W-1:0] db_cnt_q;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      key_db_q   <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      key_meta_q <= key_in;
      key_s_q    <= key_meta_q;
      // key_db follows key_s only after DEB consecutive cycles of disagreement.
      // Any cycle of agreement restarts the count, so short glitches vanish.
      if (key_s_q == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEB - 1)) begin
        key_db_q <= key_s_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Symbol FSM
  state_e           state_q, state_d;
  logic [CNT_W-1:0] press_len_q, press_len_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [2:0]       sym_cnt_q, sym_cnt_d;
  logic             symbol_valid_q, symbol_valid_d;
  logic             symbol_dot_q, symbol_dot_d;
  logic             letter_end_q, letter_end_d;
  logic             word_end_q, word_end_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // NOTE: every variable gets a default before the case statement. No path can
  // leave a variable unassigned, so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    press_len_d    = press_len_q;
    gap_len_d      = gap_len_q;
    sym_cnt_d      = sym_cnt_q;
    symbol_valid_d = 1'b0;
    symbol_dot_d   = symbol_dot_q;
    letter_end_d   = 1'b0;
    word_end_d     = 1'b0;
    err_d          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_db_q) begin
          state_d     = PRESS;
          press_len_d = CNT_W'(1);
        end
      end

      PRESS: begin
        if (key_db_q) begin
          press_len_d = (press_len_q == PRESS_SAT) ? press_len_q : press_len_q + 1'b1;
          // The press is too long to be a dash. Abandon it at once.
          if (press_len_d == PRESS_SAT) begin
            err_d     = 1'b1;
            state_d   = DISCARD;
            gap_len_d = '0;
          end
        end else if (sym_cnt_q == 3'd4) begin
          // A fifth symbol cannot belong to a valid letter.
          err_d     = 1'b1;
          state_d   = DISCARD;
          gap_len_d = '0;
        end else begin
          symbol_valid_d = 1'b1;
          symbol_dot_d   = (press_len_q <= DOT_LIM);
          sym_cnt_d      = sym_cnt_q + 3'd1;
          state_d        = GAP;
          gap_len_d      = '0;
        end
      end

      GAP: begin
        if (key_db_q) begin
          // sym_cnt was already cleared if LETTER_GAP was reached.
          state_d     = PRESS;
          press_len_d = CNT_W'(1);
        end else begin
          gap_len_d = gap_len_q + 1'b1;
          if (gap_len_d == LGAP) begin
            letter_end_d = 1'b1;
            sym_cnt_d    = '0;
          end else if (gap_len_d == WGAP) begin
            word_end_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      DISCARD: begin
        // Any press restarts the quiet-time count.
        gap_len_d = key_db_q ? '0 : gap_len_q + 1'b1;
        if (gap_len_d == LGAP) begin
          letter_end_d = 1'b1;
          sym_cnt_d    = '0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      press_len_q    <= '0;
      gap_len_q      <= '0;
      sym_cnt_q      <= '0;
      symbol_valid_q <= 1'b0;
      symbol_dot_q   <= 1'b0;
      letter_end_q   <= 1'b0;
      word_end_q     <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      press_len_q    <= press_len_d;
      gap_len_q      <= gap_len_d;
      sym_cnt_q      <= sym_cnt_d;
      symbol_valid_q <= symbol_valid_d;
      symbol_dot_q   <= symbol_dot_d;
      letter_end_q   <= letter_end_d;
      word_end_q     <= word_end_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign symbol_valid = symbol_valid_q;
  assign symbol_dot   = symbol_dot_q;
  assign letter_end   = letter_end_q;
  assign word_end     = word_end_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_morse_symbol_detector.sv
// -----------------------------------------------------------------------------
// tb_morse_symbol_detector
//
// Directed testbench for morse_symbol_detector with default parameters.
// A negedge monitor counts output pulses and timestamps them in cycles.
// Each scenario compares pulse counts and cycle distances against
// hand-computed values. Key stimulus changes just after the falling edge.
// -----------------------------------------------------------------------------
module tb_morse_symbol_detector;

  localparam int DASH_MAX   = 40;
  localparam int LETTER_GAP = 30;
  localparam int WORD_GAP   = 70;

  logic clk = 1'b0;
  logic reset;
  logic key_in;
  logic symbol_valid, symbol_dot, letter_end, word_end, err, busy;

  morse_symbol_detector dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .symbol_valid (symbol_valid),
    .symbol_dot   (symbol_dot),
    .letter_end   (letter_end),
    .word_end     (word_end),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Monitor: pulse counters and cycle stamps of the most recent events.
  int   cyc = 0;
  int   sym_n = 0, letter_n = 0, word_n = 0, err_n = 0, overlap_n = 0, busy_hi_n = 0;
  int   sym_t = 0, letter_t = 0, word_t = 0, err_t = 0, busy_rise_t = 0;
  logic busy_prev = 1'b0;
  logic dot_hist [16];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    busy_hi_n <= busy_hi_n + int'(busy);
    if (busy && !busy_prev) busy_rise_t <= cyc;
    if (symbol_valid) begin
      dot_hist[sym_n[3:0]] <= symbol_dot;
      sym_n <= sym_n + 1;
      sym_t <= cyc;
    end
    if (letter_end) begin
      letter_n <= letter_n + 1;
      letter_t <= cyc;
    end
    if (word_end) begin
      word_n <= word_n + 1;
      word_t <= cyc;
    end
    if (err) begin
      err_n <= err_n + 1;
      err_t <= cyc;
    end
    if (int'(symbol_valid) + int'(letter_end) + int'(word_end) > 1) overlap_n <= overlap_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles; returns just after the falling edge, after the monitor updated.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input int hi, input int lo);
    key_in = 1'b1;
    tick(hi);
    key_in = 1'b0;
    tick(lo);
  endtask

  int b_sym, b_letter, b_word, b_err, b_busy;

  task automatic snap();
    b_sym    = sym_n;
    b_letter = letter_n;
    b_word   = word_n;
    b_err    = err_n;
    b_busy   = busy_hi_n;
  endtask

  function automatic int outs();
    return int'({symbol_valid, symbol_dot, letter_end, word_end, err, busy});
  endfunction

  initial begin
    int waited;
    reset  = 1'b1;
    key_in = 1'b0;
    tick(3);
    check("reset_outputs", outs(), 0);
    reset = 1'b0;
    tick(5);

    // Single dot: press 6, then low 80.
    snap();
    press(6, 80);
    tick(20);
    check("s1_symbols", sym_n - b_sym, 1);
    check("s1_dot", int'(dot_hist[b_sym[3:0]]), 1);
    check("s1_press_len", sym_t - busy_rise_t, 6);
    check("s1_letter_cnt", letter_n - b_letter, 1);
    check("s1_letter_gap", letter_t - sym_t, LETTER_GAP);
    check("s1_word_cnt", word_n - b_word, 1);
    check("s1_word_gap", word_t - sym_t, WORD_GAP);
    check("s1_busy", int'(busy), 0);

    // Dash then dot within one letter.
    snap();
    press(20, 10);
    press(5, 80);
    tick(20);
    check("s2_symbols", sym_n - b_sym, 2);
    check("s2_first_dash", int'(dot_hist[b_sym[3:0]]), 0);
    check("s2_second_dot", int'(dot_hist[4'(b_sym + 1)]), 1);
    check("s2_letter_cnt", letter_n - b_letter, 1);
    check("s2_letter_gap", letter_t - sym_t, LETTER_GAP);
    check("s2_word_cnt", word_n - b_word, 1);
    check("s2_err", err_n - b_err, 0);

    // Over-long press: err on press cycle DASH_MAX+1, then discard and recover.
    snap();
    press(50, 30);
    tick(100);
    check("s3_err_cnt", err_n - b_err, 1);
    check("s3_err_time", err_t - busy_rise_t, DASH_MAX);
    check("s3_symbols", sym_n - b_sym, 0);
    check("s3_letter_cnt", letter_n - b_letter, 1);
    check("s3_word_cnt", word_n - b_word, 0);
    check("s3_busy", int'(busy), 0);

    // Five dots in one letter: four symbols, err on the fifth release.
    snap();
    for (int i = 0; i < 5; i++) press(5, 10);
    tick(60);
    check("s4_symbols", sym_n - b_sym, 4);
    for (int i = 0; i < 4; i++) check($sformatf("s4_dot%0d", i), int'(dot_hist[4'(b_sym + i)]), 1);
    check("s4_err_cnt", err_n - b_err, 1);
    check("s4_letter_cnt", letter_n - b_letter, 1);
    check("s4_letter_gap", letter_t - err_t, LETTER_GAP);
    check("s4_word_cnt", word_n - b_word, 0);
    check("s4_busy", int'(busy), 0);

    // 2-cycle glitches must never pass the debouncer.
    snap();
    for (int i = 0; i < 4; i++) press(2, 6);
    tick(20);
    check("s5_symbols", sym_n - b_sym, 0);
    check("s5_busy_cycles", busy_hi_n - b_busy, 0);
    check("s5_err", err_n - b_err, 0);

    // Reset in the middle of a press.
    key_in = 1'b1;
    waited = 0;
    while (!busy && waited < 50) begin
      tick(1);
      waited++;
    end
    check("s6_press_started", int'(busy), 1);
    tick(7);
    reset  = 1'b1;
    key_in = 1'b0;
    tick(1);
    check("s6_reset_outputs", outs(), 0);
    tick(1);
    reset = 1'b0;
    snap();
    tick(120);
    check("s6_symbols", sym_n - b_sym, 0);
    check("s6_err", err_n - b_err, 0);
    check("s6_letter", letter_n - b_letter, 0);
    check("s6_word", word_n - b_word, 0);
    check("s6_busy", int'(busy), 0);

    check("no_overlap", overlap_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
